// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for a MIPS datapath (add, sub, lw, sw, j) with a
// shared memory port, a ready handshake and a bounded wait for memory.
//
// state  | code | meaning
// IDLE   | 0    | after reset, no activity
// FETCH  | 1    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE | 2    | dispatch on op_code/funct
// EXEC_R | 3    | R-type ALU operation
// WB_R   | 4    | write ALU_out to rd
// ADDR   | 5    | effective address = A + sign-ext imm
// MEM_RD | 6    | data read at ALU_out
// WB_LD  | 7    | write MDR to rt
// MEM_WR | 8    | data write at ALU_out
// JUMP   | 9    | PC <= jump target
// HALT   | 15   | fault, held until reset
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALU_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       halted,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_state;
    logic             timeout_hit;

    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // This waiting cycle would bring the count to TIMEOUT.
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ALU_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_DECODE: begin
                if (op_code == OP_RTYPE && (funct == FN_ADD || funct == FN_SUB))
                    state_d = S_EXEC_R;
                else if (op_code == OP_LW || op_code == OP_SW)
                    state_d = S_ADDR;
                else if (op_code == OP_J)
                    state_d = S_JUMP;
                else
                    state_d = S_HALT;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                ALU_op    = (funct == FN_SUB) ? 2'b01 : 2'b00;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op_code == OP_LW)      state_d = S_MEM_RD;
                else if (op_code == OP_SW) state_d = S_MEM_WR;
                else                       state_d = S_HALT;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)        state_d = S_WB_LD;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_WB_LD: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Counter only survives while waiting in the same memory state; any entry starts it at zero.
    always_comb begin
        cnt_d = '0;
        if (mem_state && !mem_ready && state_d == state_q)
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction flows, wait states,
// illegal opcodes, memory timeout and asynchronous reset abort.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b, ALU_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, halted;
    logic [3:0] state_o;

    int n_chk  = 0;
    int n_pass = 0;

    // ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source[1:0],
    //         alu_src_a, alu_src_b[1:0], ALU_op[1:0], reg_dst, mem_to_reg, reg_write, halted}
    localparam logic [15:0] C_ZERO    = 16'h0000;
    localparam logic [15:0] C_FETCH_R = 16'h9840;
    localparam logic [15:0] C_FETCH_W = 16'h8040;
    localparam logic [15:0] C_EX_ADD  = 16'h0100;
    localparam logic [15:0] C_EX_SUB  = 16'h0110;
    localparam logic [15:0] C_WB_R    = 16'h000A;
    localparam logic [15:0] C_ADDR    = 16'h0180;
    localparam logic [15:0] C_MEM_RD  = 16'hA000;
    localparam logic [15:0] C_WB_LD   = 16'h0006;
    localparam logic [15:0] C_MEM_WR  = 16'h6000;
    localparam logic [15:0] C_JUMP    = 16'h0C00;
    localparam logic [15:0] C_HALT    = 16'h0001;

    logic [15:0] ctrl;
    assign ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                   alu_src_a, alu_src_b, ALU_op, reg_dst, mem_to_reg, reg_write, halted};

    mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_code    (op_code),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALU_op     (ALU_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .halted     (halted),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    endtask

    // Settle inputs, then compare state and control vector mid-cycle.
    task automatic expect_st(input string tag, input logic [3:0] st, input logic [15:0] c);
        #1;
        chk({tag, ".state"}, {12'h0, state_o}, {12'h0, st});
        chk({tag, ".ctrl"}, ctrl, c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst.state", {12'h0, state_o}, 16'h0);
        chk("rst.ctrl", ctrl, C_ZERO);
        cyc();
        reset_n = 1'b1;
        expect_st("idle", 4'd0, C_ZERO);
        cyc();
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        op_code   = 6'd0;
        funct     = 6'd32;
        cyc();
        do_reset();

        // add: 1,2,3,4,1
        expect_st("add.f", 4'd1, C_FETCH_R); cyc();
        expect_st("add.d", 4'd2, C_ZERO);    cyc();
        expect_st("add.x", 4'd3, C_EX_ADD);  cyc();
        expect_st("add.w", 4'd4, C_WB_R);    cyc();
        expect_st("add.f2", 4'd1, C_FETCH_R);

        // sub
        funct = 6'd34; cyc();
        expect_st("sub.d", 4'd2, C_ZERO);    cyc();
        expect_st("sub.x", 4'd3, C_EX_SUB);  cyc();
        expect_st("sub.w", 4'd4, C_WB_R);    cyc();
        expect_st("sub.f2", 4'd1, C_FETCH_R);

        // lw with three wait cycles in MEM_RD
        op_code = 6'd35; cyc();
        expect_st("lw.d", 4'd2, C_ZERO);     cyc();
        expect_st("lw.a", 4'd5, C_ADDR);     cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_st("lw.wait", 4'd6, C_MEM_RD); cyc();
        end
        mem_ready = 1'b1;
        expect_st("lw.rd", 4'd6, C_MEM_RD);  cyc();
        expect_st("lw.wb", 4'd7, C_WB_LD);   cyc();
        expect_st("lw.f2", 4'd1, C_FETCH_R);

        // sw with one wait cycle
        op_code = 6'd43; cyc();
        expect_st("sw.d", 4'd2, C_ZERO);     cyc();
        expect_st("sw.a", 4'd5, C_ADDR);     cyc();
        mem_ready = 1'b0;
        expect_st("sw.wait", 4'd8, C_MEM_WR); cyc();
        mem_ready = 1'b1;
        expect_st("sw.wr", 4'd8, C_MEM_WR);  cyc();
        expect_st("sw.f2", 4'd1, C_FETCH_R);

        // j: 1,2,9,1 ; mem_ready low in JUMP must be ignored
        op_code = 6'd2; cyc();
        expect_st("j.d", 4'd2, C_ZERO);      cyc();
        mem_ready = 1'b0;
        expect_st("j.j", 4'd9, C_JUMP);      cyc();
        mem_ready = 1'b1;
        expect_st("j.f2", 4'd1, C_FETCH_R);

        // illegal op 4 -> HALT, sticky
        op_code = 6'd4; cyc();
        expect_st("ill4.d", 4'd2, C_ZERO);   cyc();
        for (int i = 0; i < 3; i++) begin
            expect_st("ill4.h", 4'd15, C_HALT); cyc();
        end
        do_reset();

        // illegal op 0 funct 36
        op_code = 6'd0; funct = 6'd36;
        expect_st("ill36.f", 4'd1, C_FETCH_R); cyc();
        expect_st("ill36.d", 4'd2, C_ZERO);    cyc();
        expect_st("ill36.h", 4'd15, C_HALT);   cyc();
        expect_st("ill36.h2", 4'd15, C_HALT);
        do_reset();

        // fetch timeout: four waiting cycles then HALT
        funct = 6'd32; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_st("to.wait", 4'd1, C_FETCH_W); cyc();
        end
        expect_st("to.halt", 4'd15, C_HALT);
        do_reset();

        // ready on the fourth waiting cycle wins over the timeout
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_st("tr.wait", 4'd1, C_FETCH_W); cyc();
        end
        mem_ready = 1'b1;
        expect_st("tr.rdy", 4'd1, C_FETCH_R); cyc();
        expect_st("tr.dec", 4'd2, C_ZERO);    cyc();
        expect_st("tr.x", 4'd3, C_EX_ADD);    cyc();
        expect_st("tr.w", 4'd4, C_WB_R);      cyc();

        // reset_n pulsed mid MEM_WR aborts asynchronously
        op_code = 6'd43;
        expect_st("ab.f", 4'd1, C_FETCH_R);   cyc();
        expect_st("ab.d", 4'd2, C_ZERO);      cyc();
        expect_st("ab.a", 4'd5, C_ADDR);      cyc();
        mem_ready = 1'b0;
        expect_st("ab.wr", 4'd8, C_MEM_WR);
        reset_n = 1'b0;
        #1;
        chk("ab.rst.state", {12'h0, state_o}, 16'h0);
        chk("ab.rst.mem_write", {15'h0, mem_write}, 16'h0);
        chk("ab.rst.ctrl", ctrl, C_ZERO);
        cyc();
        reset_n = 1'b1; mem_ready = 1'b1;
        expect_st("ab.idle", 4'd0, C_ZERO);   cyc();
        expect_st("ab.f2", 4'd1, C_FETCH_R);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath. Supports add (op 0/funct 32), sub (op 0/funct 34), lw (op 35), sw (op 43) and j (op 2).
- Replaces single-cycle control. Instruction fetch and data access share one memory port with a ready handshake.
- Drives PC/IR write enables, the datapath mux selects and ALU_op. Halts on an illegal instruction or a memory timeout.

Parameters:
- TIMEOUT, 16: max cycles to wait for mem_ready before fault (1..255).
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op_code  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address mux: 0 = PC, 1 = ALU_out
- ir_write  out  1  load IR from memory data
- pc_write  out  1  load PC
- pc_source  out  2  00 = ALU result (PC+4), 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm
- ALU_op  out  2  00 = add, 01 = sub
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALU_out
- reg_write  out  1  register file write enable
- halted  out  1  sticky fault flag
- state_o  out  4  current state code, for debug/verification

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- While reset_n = 0: state = IDLE(0), wait counter = 0, halted = 0, all outputs 0.
- Outputs are Moore decodes of state, except ir_write and pc_write in FETCH, which are gated by mem_ready.
- Unlisted outputs are 0 in every state. No X is ever driven.
- States and codes:
  - IDLE(0): outputs 0. Next: FETCH.
  - FETCH(1): mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, ALU_op = 00, pc_source = 00.
    - mem_ready = 1: ir_write = 1 and pc_write = 1 in the same cycle. Next: DECODE.
    - Otherwise stay.
  - DECODE(2): no memory access. Next state by opcode:
    - op 0 with funct 32/34: EXEC_R.
    - op 35/43: ADDR.
    - op 2: JUMP.
    - Anything else, including op 0 with another funct: HALT.
  - EXEC_R(3): alu_src_a = 1, alu_src_b = 00, ALU_op = 00 for funct 32, 01 for funct 34. Next: WB_R.
  - WB_R(4): reg_dst = 1, mem_to_reg = 0, reg_write = 1. Next: FETCH.
  - ADDR(5): alu_src_a = 1, alu_src_b = 10, ALU_op = 00. Next: MEM_RD for op 35, MEM_WR for op 43.
  - MEM_RD(6): mem_read = 1, i_or_d = 1. mem_ready: next WB_LD.
  - WB_LD(7): reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next: FETCH.
  - MEM_WR(8): mem_write = 1, i_or_d = 1. mem_ready: next FETCH.
  - JUMP(9): pc_source = 10, pc_write = 1. Next: FETCH.
  - HALT(15): halted = 1, all other outputs 0. Held until reset.
- Latency with zero-wait memory: add/sub 4 cycles, lw 5, sw 4, j 3.
- Memory handshake:
  - Request stays asserted with a stable address until mem_ready is sampled high.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
  - mem_read and mem_write are never both 1.
- Wait counter:
  - Clears on entry to any memory state.
  - Increments each cycle the state is FETCH, MEM_RD or MEM_WR and mem_ready = 0.
  - If it reaches TIMEOUT with mem_ready still 0: next state HALT.
  - mem_ready in the same cycle the counter hits TIMEOUT takes priority: no fault.
- op_code and funct are sampled only in DECODE, EXEC_R and ADDR. The IR is stable after FETCH.
- reset_n asserted mid-instruction aborts immediately to IDLE. No partial write is retried.

Test Plan:
- Reset, mem_ready tied to 1, IR = add (0/32) -> state_o sequence 0,1,2,3,4,1. reg_write = 1 only in state 4 with reg_dst = 1. pc_write pulses once in FETCH.
- sub (0/34) -> ALU_op = 01 in EXEC_R. lw (35) with 3 mem_ready-low cycles in MEM_RD -> mem_read and i_or_d = 1 held for 4 cycles, then WB_LD with reg_write = 1, mem_to_reg = 1, reg_dst = 0.
- sw (43) -> mem_write = 1 in MEM_WR only. reg_write stays 0 throughout. Return to FETCH on mem_ready.
- j (2) -> states 1,2,9,1. In JUMP, pc_write = 1 and pc_source = 10. No memory request in JUMP.
- Illegal instructions (op 4; op 0 funct 36) -> HALT after DECODE, halted = 1 sticky, all enables 0. reset_n low clears it.
- TIMEOUT = 4, mem_ready held 0 in FETCH -> HALT after 4 waiting cycles. Repeat with mem_ready = 1 on the 4th cycle -> DECODE, no fault. reset_n pulsed in MEM_WR -> mem_write drops asynchronously, state_o = 0.
